// File: rtl/ysyx_23060059_arb_pkg.sv
// Shared definitions for the AXI read arbiter: FSM state encoding,
// one-hot grant encodings ({lsu,ifu}) and a small decode helper.
package ysyx_23060059_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IFU  = 2'b01;
    localparam logic [1:0] GNT_LSU  = 2'b10;

    // True when the grant vector names the LSU port.
    function automatic logic gnt_is_lsu(input logic [1:0] gnt);
        return (gnt == GNT_LSU);
    endfunction

endpackage

// File: rtl/ysyx_23060059_arb_picker.sv
// Grant selection for the two read masters.
// With ARB_ROUND_ROBIN_EN defined, a tie goes to the master that did not
// own the previous transaction; otherwise the LSU always wins a tie.
module ysyx_23060059_arb_picker
    import ysyx_23060059_arb_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  logic       last_lsu,
    output logic [1:0] grant
);

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority does not look at history; tie the input off here.
    logic unused_last_lsu_s;
    assign unused_last_lsu_s = last_lsu;
`endif

    // Pick one requester, one-hot, or GNT_NONE when nobody asks.
    always_comb begin
        grant = GNT_NONE;
        if (ifu_valid && lsu_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (last_lsu) begin
                grant = GNT_IFU;
            end else begin
                grant = GNT_LSU;
            end
`else
            grant = GNT_LSU;
`endif
        end else if (lsu_valid) begin
            grant = GNT_LSU;
        end else if (ifu_valid) begin
            grant = GNT_IFU;
        end else begin
            grant = GNT_NONE;
        end
    end

endmodule

// File: rtl/ysyx_23060059_axi_rd_arb.sv
// Two-master (IFU/LSU) AXI read arbiter onto one memory port.
// One transaction outstanding at a time: IDLE -> ADDR -> DATA -> IDLE.
// Channels are forwarded combinationally from the latched grant.
// Optional macro: ARB_ROUND_ROBIN_EN (round-robin ties instead of LSU priority).
module ysyx_23060059_axi_rd_arb
    import ysyx_23060059_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    // IFU port
    input  logic              ifu_arvalid,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic [ID_W-1:0]   ifu_arid,
    input  logic [7:0]        ifu_arlen,
    input  logic [2:0]        ifu_arsize,
    input  logic [1:0]        ifu_arburst,
    output logic              ifu_arready,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    output logic              ifu_rlast,
    output logic [ID_W-1:0]   ifu_rid,
    input  logic              ifu_rready,
    // LSU port
    input  logic              lsu_arvalid,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [ID_W-1:0]   lsu_arid,
    input  logic [7:0]        lsu_arlen,
    input  logic [2:0]        lsu_arsize,
    input  logic [1:0]        lsu_arburst,
    output logic              lsu_arready,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    output logic              lsu_rlast,
    output logic [ID_W-1:0]   lsu_rid,
    input  logic              lsu_rready,
    // Shared memory port
    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [ID_W-1:0]   s_arid,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic [ID_W-1:0]   s_rid,
    output logic              s_rready,
    output logic [1:0]        grant
);

    arb_state_e state_r;
    logic [1:0] grant_r;
    logic [1:0] pick_s;
    logic       last_lsu_s;
    logic       sel_lsu_s;

    ysyx_23060059_arb_picker u_picker (
        .ifu_valid (ifu_arvalid),
        .lsu_valid (lsu_arvalid),
        .last_lsu  (last_lsu_s),
        .grant     (pick_s)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic last_lsu_r;

    // Remember which master owned the most recent grant (IFU after reset).
    always_ff @(posedge clock) begin
        if (reset) begin
            last_lsu_r <= 1'b0;
        end else if ((state_r == IDLE) && (pick_s != GNT_NONE)) begin
            last_lsu_r <= gnt_is_lsu(pick_s);
        end
    end

    assign last_lsu_s = last_lsu_r;
`else
    assign last_lsu_s = 1'b0;
`endif

    assign grant     = grant_r;
    assign sel_lsu_s = gnt_is_lsu(grant_r);

    // Transaction sequencing; the grant is latched in IDLE and held until
    // the last read beat handshakes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            grant_r <= GNT_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_s != GNT_NONE) begin
                        state_r <= ADDR;
                        grant_r <= pick_s;
                    end
                end
                ADDR: begin
                    if (s_arvalid && s_arready) begin
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (s_rvalid && s_rready && s_rlast) begin
                        state_r <= IDLE;
                        grant_r <= GNT_NONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= GNT_NONE;
                end
            endcase
        end
    end

    // Channel routing: AR from the owner in ADDR, R to the owner in DATA,
    // everything quiet otherwise. s_rid is passed through untouched.
    always_comb begin
        s_arvalid   = 1'b0;
        s_araddr    = {ADDR_W{1'b0}};
        s_arid      = {ID_W{1'b0}};
        s_arlen     = 8'd0;
        s_arsize    = 3'd0;
        s_arburst   = 2'd0;
        s_rready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = {DATA_W{1'b0}};
        ifu_rresp   = 2'd0;
        ifu_rlast   = 1'b0;
        ifu_rid     = {ID_W{1'b0}};
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = {DATA_W{1'b0}};
        lsu_rresp   = 2'd0;
        lsu_rlast   = 1'b0;
        lsu_rid     = {ID_W{1'b0}};
        case (state_r)
            ADDR: begin
                if (sel_lsu_s) begin
                    s_arvalid   = lsu_arvalid;
                    s_araddr    = lsu_araddr;
                    s_arid      = lsu_arid;
                    s_arlen     = lsu_arlen;
                    s_arsize    = lsu_arsize;
                    s_arburst   = lsu_arburst;
                    lsu_arready = s_arready;
                end else begin
                    s_arvalid   = ifu_arvalid;
                    s_araddr    = ifu_araddr;
                    s_arid      = ifu_arid;
                    s_arlen     = ifu_arlen;
                    s_arsize    = ifu_arsize;
                    s_arburst   = ifu_arburst;
                    ifu_arready = s_arready;
                end
            end
            DATA: begin
                if (sel_lsu_s) begin
                    lsu_rvalid = s_rvalid;
                    lsu_rdata  = s_rdata;
                    lsu_rresp  = s_rresp;
                    lsu_rlast  = s_rlast;
                    lsu_rid    = s_rid;
                    s_rready   = lsu_rready;
                end else begin
                    ifu_rvalid = s_rvalid;
                    ifu_rdata  = s_rdata;
                    ifu_rresp  = s_rresp;
                    ifu_rlast  = s_rlast;
                    ifu_rid    = s_rid;
                    s_rready   = ifu_rready;
                end
            end
            default: begin
                s_arvalid = 1'b0;
                s_rready  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060059_axi_rd_arb.sv
// Directed self-checking bench for ysyx_23060059_axi_rd_arb.
module tb_ysyx_23060059_axi_rd_arb;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_IFU  = 2'b01;
    localparam logic [1:0] G_LSU  = 2'b10;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready;
    logic [31:0] ifu_araddr;
    logic [3:0]  ifu_arid, ifu_rid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic [63:0] ifu_rdata;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready;
    logic [31:0] lsu_araddr;
    logic [3:0]  lsu_arid, lsu_rid;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst, lsu_rresp;
    logic [63:0] lsu_rdata;
    logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;
    logic [63:0] s_rdata;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060059_axi_rd_arb dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid),
        .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
        .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid),
        .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
        .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
        .lsu_rready(lsu_rready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid), .s_rready(s_rready),
        .grant(grant)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs follow newly driven inputs.
    task automatic settle();
        #1;
    endtask

    // One single-beat read, starting in IDLE with the request(s) already driven.
    task automatic xact(input string tag, input logic [1:0] exp_gnt,
                        input logic [31:0] exp_addr, input logic [63:0] rdata,
                        input logic [1:0] rresp, input logic drop_all);
        step();                       // now ADDR
        settle();
        chk({tag, ":grant"}, grant, exp_gnt);
        chk({tag, ":s_arvalid"}, s_arvalid, 1'b1);
        chk({tag, ":s_araddr"}, s_araddr, exp_addr);
        chk({tag, ":ifu_arready"}, ifu_arready, exp_gnt[0]);
        chk({tag, ":lsu_arready"}, lsu_arready, exp_gnt[1]);
        step();                       // now DATA
        if (exp_gnt == G_LSU) lsu_arvalid = 1'b0;
        else ifu_arvalid = 1'b0;
        if (drop_all) begin
            ifu_arvalid = 1'b0;
            lsu_arvalid = 1'b0;
        end
        s_rvalid = 1'b1; s_rdata = rdata; s_rresp = rresp; s_rlast = 1'b1; s_rid = 4'd9;
        ifu_rready = 1'b1; lsu_rready = 1'b1;
        settle();
        chk({tag, ":ifu_rvalid"}, ifu_rvalid, exp_gnt[0]);
        chk({tag, ":lsu_rvalid"}, lsu_rvalid, exp_gnt[1]);
        chk({tag, ":rdata"}, (exp_gnt == G_LSU) ? lsu_rdata : ifu_rdata, rdata);
        chk({tag, ":rresp"}, (exp_gnt == G_LSU) ? lsu_rresp : ifu_rresp, rresp);
        chk({tag, ":rid"}, (exp_gnt == G_LSU) ? lsu_rid : ifu_rid, 4'd9);
        chk({tag, ":s_rready"}, s_rready, 1'b1);
        step();                       // back to IDLE
        s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = 2'b00;
        settle();
        chk({tag, ":idle_grant"}, grant, G_NONE);
        chk({tag, ":idle_s_arvalid"}, s_arvalid, 1'b0);
        chk({tag, ":idle_arready"}, {lsu_arready, ifu_arready}, 2'b00);
    endtask

    initial begin
        logic [1:0] exp_tie;
        int beat;

        reset = 1'b1;
        ifu_arvalid = 1'b0; ifu_araddr = 32'h0; ifu_arid = 4'h0; ifu_arlen = 8'd0;
        ifu_arsize = 3'd3; ifu_arburst = 2'd1; ifu_rready = 1'b0;
        lsu_arvalid = 1'b0; lsu_araddr = 32'h0; lsu_arid = 4'h0; lsu_arlen = 8'd0;
        lsu_arsize = 3'd3; lsu_arburst = 2'd1; lsu_rready = 1'b0;
        s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = 64'h0; s_rresp = 2'b00;
        s_rlast = 1'b0; s_rid = 4'h0;
        step();
        step();
        settle();
        chk("rst:grant", grant, G_NONE);
        chk("rst:s_arvalid", s_arvalid, 1'b0);
        chk("rst:s_rready", s_rready, 1'b0);
        reset = 1'b0;

        // IFU single beat: s_arvalid exactly one cycle after request seen in IDLE
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; ifu_arid = 4'd3;
        settle();
        chk("ifu1:pre_s_arvalid", s_arvalid, 1'b0);
        chk("ifu1:pre_arready", ifu_arready, 1'b0);
        xact("ifu1", G_IFU, 32'h8000_0000, 64'h1234_0013, 2'b00, 1'b0);

        // Simultaneous requests: LSU wins in both builds (last owner is IFU)
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_1000;
        xact("tie1_lsu", G_LSU, 32'h8000_1000, 64'hAAAA_0001, 2'b00, 1'b0);
        // IFU was left waiting and is taken after the mandatory IDLE cycle
        xact("tie1_ifu", G_IFU, 32'h8000_0000, 64'hBBBB_0002, 2'b00, 1'b0);

        // LSU burst of 4 with AR stall and a dropped arvalid in ADDR
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2000; lsu_arlen = 8'd3;
        s_arready = 1'b0;
        step();                       // ADDR
        settle();
        chk("burst:grant", grant, G_LSU);
        chk("burst:s_arlen", s_arlen, 8'd3);
        chk("burst:stall_arready", lsu_arready, 1'b0);
        lsu_arvalid = 1'b0;           // protocol violation: must not disturb ADDR
        step();
        settle();
        chk("burst:drop_grant", grant, G_LSU);
        chk("burst:drop_s_arvalid", s_arvalid, 1'b0);
        lsu_arvalid = 1'b1; s_arready = 1'b1;
        settle();
        chk("burst:arready", lsu_arready, 1'b1);
        step();                       // DATA
        lsu_arvalid = 1'b0; lsu_arlen = 8'd0;
        ifu_rready = 1'b1;
        beat = 0;
        for (int i = 0; i < 8; i++) begin
            s_rvalid = 1'b1;
            s_rdata = 64'hC0DE_0000 + 64'(beat);
            s_rlast = (beat == 3);
            lsu_rready = i[0];
            settle();
            chk("burst:grant_data", grant, G_LSU);
            chk("burst:s_rready", s_rready, lsu_rready);
            chk("burst:lsu_rvalid", lsu_rvalid, 1'b1);
            chk("burst:lsu_rdata", lsu_rdata, 64'hC0DE_0000 + 64'(beat));
            chk("burst:ifu_rvalid", ifu_rvalid, 1'b0);
            step();
            if (lsu_rready) beat++;
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        settle();
        chk("burst:beats", beat, 4);
        chk("burst:end_grant", grant, G_NONE);

        // Simultaneous again, last owner now LSU
`ifdef ARB_ROUND_ROBIN_EN
        exp_tie = G_IFU;
`else
        exp_tie = G_LSU;
`endif
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0040;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_1040;
        xact("tie2", exp_tie, (exp_tie == G_IFU) ? 32'h8000_0040 : 32'h8000_1040,
             64'hDDDD_0003, 2'b00, 1'b1);

        // Error response is forwarded and sequencing is unchanged
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0080;
        xact("slverr", G_IFU, 32'h8000_0080, 64'hEEEE_0004, 2'b10, 1'b0);

        // Reset during DATA with a beat on the bus
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_00C0;
        step();                       // ADDR
        step();                       // DATA
        ifu_arvalid = 1'b0;
        s_rvalid = 1'b1; s_rdata = 64'hFFFF_0005; s_rlast = 1'b0;
        settle();
        chk("rstd:pre_rvalid", ifu_rvalid, 1'b1);
        reset = 1'b1;
        step();
        settle();
        chk("rstd:grant", grant, G_NONE);
        chk("rstd:s_rready", s_rready, 1'b0);
        chk("rstd:rvalid", {lsu_rvalid, ifu_rvalid}, 2'b00);
        chk("rstd:ifu_rdata", ifu_rdata, 64'h0);
        chk("rstd:s_arvalid", s_arvalid, 1'b0);
        reset = 1'b0; s_rvalid = 1'b0;
        step();
        settle();
        chk("rstd:idle_grant", grant, G_NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060059_axi_rd_arb.md
YSYX_23060059_AXI_RD_ARB -- requirements
Module: ysyx_23060059_axi_rd_arb

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all AR channels.
REQ-002 Parameter DATA_W, default 64, R data width.
REQ-003 Parameter ID_W, default 4, arid/rid width.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ifu_arvalid, ifu_araddr, ifu_arid, ifu_arlen, ifu_arsize, ifu_arburst  input  1/ADDR_W/ID_W/8/3/2  IFU read request.
REQ-007 ifu_arready  output  1  IFU AR accept.
REQ-008 ifu_rvalid, ifu_rdata, ifu_rresp, ifu_rlast, ifu_rid  output  1/DATA_W/2/1/ID_W  IFU read response.
REQ-009 ifu_rready  input  1  IFU R accept.
REQ-010 lsu_* ports  same names, directions and widths as REQ-006..009 with prefix lsu_  LSU read port.
REQ-011 s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst  output  as REQ-006  shared memory AR.
REQ-012 s_arready  input  1  memory AR accept.
REQ-013 s_rvalid, s_rdata, s_rresp, s_rlast, s_rid  input  as REQ-008  memory R.
REQ-014 s_rready  output  1  memory R accept.
REQ-015 grant  output  2  one-hot owner {lsu,ifu}, 2'b00 when idle.

Function
REQ-016 The block SHALL implement states IDLE, ADDR, DATA; exactly one read transaction outstanding at a time.
REQ-017 IDLE: s_arvalid=0, s_rready=0, all master arready/rvalid=0; if any master arvalid=1, latch grant and go to ADDR next cycle.
REQ-018 ADDR: all s_ar* driven combinationally from the granted master; granted arready = s_arready; other arready=0; on s_arvalid&s_arready go to DATA.
REQ-019 Arbitration latency SHALL be exactly one cycle: arvalid seen in IDLE at edge N gives s_arvalid=1 in cycle N+1.
REQ-020 DATA: granted rvalid/rdata/rresp/rlast/rid = s_r* combinationally; s_rready = granted rready; other master rvalid=0.
REQ-021 DATA SHALL exit to IDLE only on s_rvalid&s_rready&s_rlast; non-last beats keep DATA (bursts arlen>0 supported).
REQ-022 rresp SHALL be forwarded unchanged; error responses do not alter sequencing.
REQ-023 Response routing SHALL use the latched grant only; s_rid is forwarded, never compared.
REQ-024 Granted master dropping arvalid in ADDR (protocol violation) SHALL not change state or grant.
REQ-025 The non-granted master's pending arvalid SHALL wait with arready=0 and be arbitrated in the next IDLE.
REQ-026 IDLE lasts one cycle minimum between transactions; no back-to-back bypass.

Reset
REQ-027 On reset: state=IDLE, grant=00, last-owner register=IFU, all outputs 0 the cycle after reset asserts.
REQ-028 Reset mid-ADDR or mid-DATA SHALL abort to IDLE; any in-flight memory beat is dropped (s_rready=0).

Configuration
REQ-029 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests grant the master not owning the previous transaction; last-owner updates on every grant.
REQ-030 Without ARB_ROUND_ROBIN_EN: fixed priority, LSU wins simultaneous requests; last-owner register absent.

Structure
REQ-031 Package ysyx_23060059_arb_pkg SHALL hold the state enum (IDLE/ADDR/DATA) and grant encodings GNT_NONE/GNT_IFU/GNT_LSU.
REQ-032 Grant selection SHALL live in one sub-module ysyx_23060059_arb_picker (inputs: two valids, last-owner; output: one-hot grant).

Verification
REQ-033 IFU only, araddr=0x80000000, s_arready=1, single beat rdata=0x1234_0013 -> s_arvalid cycle N+1, ifu_rvalid with that data, grant 01 then 00.
REQ-034 IFU and LSU arvalid same cycle, no macro -> LSU (0x80001000) served first, IFU next after IDLE; with macro and last-owner=IFU -> LSU first, then repeat -> IFU first.
REQ-035 LSU burst arlen=3, s_rready toggled by lsu_rready -> 4 beats delivered, DATA exits only on rlast handshake, ifu_rvalid stays 0.
REQ-036 s_rresp=2'b10 on IFU read -> ifu_rresp=2'b10, return to IDLE normally.
REQ-037 reset asserted during DATA with s_rvalid=1 -> next cycle IDLE, grant=00, s_rready=0, all master outputs 0.
